// File: rtl/debounce_edge.sv
// Debounces one asynchronous pushbutton/switch input: synchroniser, counter-qualified
// four-state FSM, registered level plus single-cycle rise/fall pulses.
module debounce_edge #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic rst_asyn,
  input  logic enable,
  input  logic btn_in,
  output logic btn_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] N = CNT_WIDTH'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_out;
  state_t                 r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt;
  logic                   w_rise_nxt, w_fall_nxt;
  logic                   r_level, r_rise, r_fall, r_busy;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge rst_asyn) begin
    if (rst_asyn) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
  end

  always_ff @(posedge clock or posedge rst_asyn) begin
    if (rst_asyn) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (enable && w_sync_out) begin
          w_state_nxt = CHECK_HIGH;
          w_cnt_nxt   = CNT_WIDTH'(1);
        end
      end
      CHECK_HIGH: begin
        if (!enable || !w_sync_out) begin
          w_state_nxt = IDLE_LOW;
        end else if (r_cnt == N) begin
          w_state_nxt = IDLE_HIGH;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      IDLE_HIGH: begin
        if (enable && !w_sync_out) begin
          w_state_nxt = CHECK_LOW;
          w_cnt_nxt   = CNT_WIDTH'(1);
        end
      end
      CHECK_LOW: begin
        if (!enable || w_sync_out) begin
          w_state_nxt = IDLE_HIGH;
        end else if (r_cnt == N) begin
          w_state_nxt = IDLE_LOW;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      default: w_state_nxt = IDLE_LOW;
    endcase
  end

  // Outputs decoded from the next state into their own flops so they change on the
  // same edge as the state while having no combinational path from any input.
  always_ff @(posedge clock or posedge rst_asyn) begin
    if (rst_asyn) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_level <= (w_state_nxt == IDLE_HIGH) || (w_state_nxt == CHECK_LOW);
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= (w_state_nxt == CHECK_HIGH) || (w_state_nxt == CHECK_LOW);
    end
  end

  assign btn_level  = r_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign busy       = r_busy;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed-vector bench for debounce_edge with S=2, N=4; outputs compared as
// {btn_level, rise_pulse, fall_pulse, busy} one time unit after each rising edge.
module tb_debounce_edge;

  logic clock = 1'b0;
  logic rst_asyn, enable, btn_in;
  logic btn_level, rise_pulse, fall_pulse, busy;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  debounce_edge #(
    .SYNC_STAGES    (2),
    .CNT_WIDTH      (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock     (clock),
    .rst_asyn  (rst_asyn),
    .enable    (enable),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check_vec(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b ({level,rise,fall,busy})", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One edge, then compare the output vector.
  task automatic step(input string tag, input logic [3:0] exp);
    tick();
    check_vec(tag, {btn_level, rise_pulse, fall_pulse, busy}, exp);
  endtask

  // Standard qualification of a held change from 'from_lvl': edges 0..7.
  task automatic run_commit(input string tag, input logic from_lvl);
    logic [3:0] idle_v, chk_v, com_v, after_v;
    idle_v  = {from_lvl, 3'b000};
    chk_v   = {from_lvl, 3'b001};
    com_v   = from_lvl ? 4'b0010 : 4'b1100;
    after_v = {~from_lvl, 3'b000};
    for (int k = 0; k < 8; k++) begin
      step($sformatf("%s e%0d", tag, k),
           (k < 2) ? idle_v : (k < 6) ? chk_v : (k == 6) ? com_v : after_v);
    end
  endtask

  logic       bounce_in   [13] = '{1,1,1,0,0,1,1,1,1,0,0,0,0};
  logic [3:0] bounce_busy [13] = '{0,0,1,1,1,0,0,1,1,1,1,0,0};

  initial begin
    rst_asyn = 1'b1;
    enable   = 1'b1;
    btn_in   = 1'b0;
    #12;
    check_vec("reset held", {btn_level, rise_pulse, fall_pulse, busy}, 4'b0000);
    rst_asyn = 1'b0;
    for (int k = 0; k < 20; k++) step($sformatf("post-reset c%0d", k), 4'b0000);

    btn_in = 1'b1;
    run_commit("press", 1'b0);
    btn_in = 1'b0;
    run_commit("release", 1'b1);

    // Async reset while level is high: outputs clear before any clock edge.
    btn_in = 1'b1;
    repeat (8) tick();
    check_vec("level high before reset", {btn_level, rise_pulse, fall_pulse, busy}, 4'b1000);
    btn_in = 1'b0;
    #2 rst_asyn = 1'b1;
    #1 check_vec("async reset immediate", {btn_level, rise_pulse, fall_pulse, busy}, 4'b0000);
    #2 rst_asyn = 1'b0;
    for (int k = 0; k < 3; k++) step($sformatf("after reset c%0d", k), 4'b0000);

    // Bounce: 3 high, 2 low, 4 high, low; second burst reaches cnt=4 but never commits.
    for (int k = 0; k < 13; k++) begin
      btn_in = bounce_in[k];
      step($sformatf("bounce e%0d", k), bounce_busy[k]);
    end

    // Enable gating two cycles into CHECK_HIGH.
    btn_in = 1'b1;
    step("gate e0", 4'b0000);
    step("gate e1", 4'b0000);
    step("gate e2", 4'b0001);
    step("gate e3", 4'b0001);
    enable = 1'b0;
    step("gate abort", 4'b0000);
    for (int k = 0; k < 10; k++) step($sformatf("gate off c%0d", k), 4'b0000);
    enable = 1'b1;
    for (int k = 0; k < 4; k++) step($sformatf("gate on e%0d", k), 4'b0001);
    step("gate on commit", 4'b1100);
    step("gate on after", 4'b1000);

    btn_in = 1'b0;
    run_commit("release2", 1'b1);

    // Reset mid-CHECK at cnt=3, then a full requalification.
    btn_in = 1'b1;
    step("midchk e0", 4'b0000);
    step("midchk e1", 4'b0000);
    step("midchk e2", 4'b0001);
    step("midchk e3", 4'b0001);
    step("midchk e4", 4'b0001);
    #2 rst_asyn = 1'b1;
    #1 check_vec("midchk reset", {btn_level, rise_pulse, fall_pulse, busy}, 4'b0000);
    #2 rst_asyn = 1'b0;
    run_commit("requal", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
